// File: rtl/vedic_pkg.sv
// Shared types and helpers for the Vedic dot-product accumulator.
package vedic_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vedic_mult_core.sv
// Combinational WIDTH x WIDTH unsigned Vedic multiplier, built recursively
// from the 2-bit cell (four half-width products merged by adders).
module vedic_mult_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    generate
        if (WIDTH == 2) begin : g_cell
            logic c1;
            assign p[0] = a[0] & b[0];
            assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[2] = (a[1] & b[1]) ^ c1;
            assign p[3] = (a[1] & b[1]) & c1;
        end else begin : g_split
            localparam int unsigned H = WIDTH / 2;

            logic [WIDTH-1:0] ll;
            logic [WIDTH-1:0] lh;
            logic [WIDTH-1:0] hl;
            logic [WIDTH-1:0] hh;
            logic [WIDTH:0]   mid;

            vedic_mult_core #(.WIDTH(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(ll));
            vedic_mult_core #(.WIDTH(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(lh));
            vedic_mult_core #(.WIDTH(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(hl));
            vedic_mult_core #(.WIDTH(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(hh));

            // Cross terms sit H bits up; hh and ll tile the result without overlap.
            assign mid = (WIDTH+1)'(lh) + (WIDTH+1)'(hl);
            assign p   = {hh, ll} + ((2*WIDTH)'(mid) << H);
        end
    endgenerate

endmodule

// File: rtl/vedic_dot_acc.sv
// Streaming dot-product accumulator over LEN Vedic products with a held,
// handshaked result. Define VEDIC_DOT_SAT_EN to saturate instead of wrap.
module vedic_dot_acc
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LEN       = 4,
    parameter int unsigned ACC_WIDTH = 2*WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 overflow
);

    localparam int unsigned PW    = 2*WIDTH;
    localparam int unsigned CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     term_cnt;
    logic [PW-1:0]        prod_c;
    logic [PW-1:0]        p_r;
    logic                 p_v;
    logic                 p_first;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH:0]   sum_c;
    logic                 accept_c;
    logic                 last_c;

    vedic_mult_core #(.WIDTH(WIDTH)) u_mult (
        .a (a),
        .b (b),
        .p (prod_c)
    );

    assign accept_c = in_valid && in_ready;
    assign last_c   = accept_c && (term_cnt == LAST);
    assign sum_c    = {1'b0, acc_r} + (ACC_WIDTH+1)'(p_r);
    assign acc_out  = acc_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            term_cnt  <= '0;
            p_r       <= '0;
            p_v       <= 1'b0;
            p_first   <= 1'b0;
            acc_r     <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            term_cnt  <= '0;
            p_v       <= 1'b0;
            p_first   <= 1'b0;
            acc_r     <= '0;
            overflow  <= 1'b0;
        end else begin
            // Product stage: one pair per accept, tagged with block position.
            p_v <= accept_c;
            if (accept_c) begin
                p_r      <= prod_c;
                p_first  <= (term_cnt == '0);
                term_cnt <= last_c ? '0 : term_cnt + CNT_W'(1);
                if (term_cnt == '0) begin
                    overflow <= 1'b0;
                end
            end

            // Accumulate stage: first product loads, later ones add with carry check.
            if (p_v) begin
                if (p_first) begin
                    acc_r <= ACC_WIDTH'(p_r);
                end else if (sum_c[ACC_WIDTH]) begin
                    overflow <= 1'b1;
`ifdef VEDIC_DOT_SAT_EN
                    acc_r    <= '1;
`else
                    acc_r    <= sum_c[ACC_WIDTH-1:0];
`endif
                end else begin
                    acc_r <= sum_c[ACC_WIDTH-1:0];
                end
            end

            case (state)
                IDLE, ACC: begin
                    if (last_c) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end else if (accept_c) begin
                        state <= ACC;
                    end
                end
                DRAIN: begin
                    if (!p_v) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_dot_acc.sv
// Self-checking bench for vedic_dot_acc: wide (20b), narrow (16b) and LEN=1
// instances against constant vectors and an arithmetic reference model.
module tb_vedic_dot_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        in_ready0, out_valid0, ovf0;
    logic [19:0] acc0;
    logic        in_ready1, out_valid1, ovf1;
    logic [15:0] acc1;

    logic        clr2 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        out_ready2 = 1'b0;
    logic [7:0]  a2 = '0;
    logic [7:0]  b2 = '0;
    logic        in_ready2, out_valid2, ovf2;
    logic [19:0] acc2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vedic_dot_acc #(.WIDTH(8), .LEN(4)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .acc_out(acc0), .overflow(ovf0));

    vedic_dot_acc #(.WIDTH(8), .LEN(4), .ACC_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .acc_out(acc1), .overflow(ovf1));

    vedic_dot_acc #(.WIDTH(8), .LEN(1)) u2 (
        .clk(clk), .rst(rst), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .acc_out(acc2), .overflow(ovf2));

    typedef struct {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        bit              gap;
        int              hold;
        logic [19:0]     e0;
        bit              o0;
        logic [15:0]     e1;
        bit              o1;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum of products reduced to w bits, wrap or clamp.
    function automatic void model(input logic [3:0][7:0] va, input logic [3:0][7:0] vb,
                                  input int w, output longint unsigned acc, output bit ovf);
        longint unsigned lim = 64'd1 << w;
        longint unsigned s;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = acc + longint'(va[i]) * longint'(vb[i]);
            if (s >= lim) begin
                ovf = 1'b1;
`ifdef VEDIC_DOT_SAT_EN
                acc = lim - 1;
`else
                acc = s % lim;
`endif
            end else begin
                acc = s;
            end
        end
    endfunction

    task automatic send_block(input logic [3:0][7:0] va, input logic [3:0][7:0] vb, input bit gap);
        for (int i = 0; i < 4; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                a = 8'($urandom);
                b = 8'($urandom);
                step();
                check("gap_ready", in_ready0, 1);
            end
            in_valid = 1'b1;
            a = va[i];
            b = vb[i];
            check("accept_ready", in_ready0, 1);
            step();
        end
        in_valid = 1'b0;
        check("drain_ready", in_ready0, 0);
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (out_valid0 !== 1'b1 && cnt < 10) begin
            step();
            cnt++;
        end
    endtask

    task automatic finish_block(input logic [19:0] e0, input bit o0,
                                input logic [15:0] e1, input bit o1, input int hold);
        int cnt;
        wait_valid(cnt);
        check("latency", cnt, 2);
        check("acc20", acc0, e0);
        check("ovf20", ovf0, o0);
        check("valid16", out_valid1, 1);
        check("acc16", acc1, e1);
        check("ovf16", ovf1, o1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = 8'd1;
            b = 8'd1;
            step();
            check("hold_valid", out_valid0, 1);
            check("hold_ready", in_ready0, 0);
            check("hold_acc20", acc0, e0);
            check("hold_acc16", acc1, e1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_valid", out_valid0, 0);
        check("release_ready", in_ready0, 1);
    endtask

    initial begin
        logic [3:0][7:0] va, vb;
        longint unsigned m20, m16;
        bit o20, o16;
        int cnt;

        vecs[0] = '{a: {8'd0, 8'd255, 8'd2, 8'd3}, b: {8'd9, 8'd255, 8'd7, 8'd5},
                    gap: 1'b0, hold: 0, e0: 20'd65054, o0: 1'b0, e1: 16'hFE1E, o1: 1'b0};
`ifdef VEDIC_DOT_SAT_EN
        vecs[1] = '{a: {4{8'd255}}, b: {4{8'd255}},
                    gap: 1'b0, hold: 5, e0: 20'h3F804, o0: 1'b0, e1: 16'hFFFF, o1: 1'b1};
`else
        vecs[1] = '{a: {4{8'd255}}, b: {4{8'd255}},
                    gap: 1'b0, hold: 5, e0: 20'h3F804, o0: 1'b0, e1: 16'hF804, o1: 1'b1};
`endif
        vecs[2] = '{a: {4{8'd1}}, b: {4{8'd1}},
                    gap: 1'b0, hold: 0, e0: 20'd4, o0: 1'b0, e1: 16'd4, o1: 1'b0};
        vecs[3] = '{a: {8'd70, 8'd50, 8'd30, 8'd10}, b: {8'd80, 8'd60, 8'd40, 8'd20},
                    gap: 1'b1, hold: 2, e0: 20'd10000, o0: 1'b0, e1: 16'd10000, o1: 1'b0};

        // Asynchronous reset values.
        #1 rst = 1'b1;
        #2;
        check("rst_ready", in_ready0, 1);
        check("rst_valid", out_valid0, 0);
        check("rst_acc", acc0, 0);
        check("rst_ovf", ovf0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Reset mid-stream while a result is held.
        send_block({4{8'd255}}, {4{8'd255}}, 1'b0);
        wait_valid(cnt);
        check("pre_rst_valid", out_valid0, 1);
        check("pre_rst_ovf16", ovf1, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid0, 0);
        check("async_rst_ready", in_ready0, 1);
        check("async_rst_acc", acc0, 0);
        check("async_rst_ovf16", ovf1, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_ready", in_ready0, 1);

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            send_block(vecs[v].a, vecs[v].b, vecs[v].gap);
            finish_block(vecs[v].e0, vecs[v].o0, vecs[v].e1, vecs[v].o1, vecs[v].hold);
        end

        // clr after two accepts, same cycle as a valid pair.
        in_valid = 1'b1;
        a = 8'd9;
        b = 8'd9;
        step();
        step();
        clr = 1'b1;
        check("clr_pre_ready", in_ready0, 1);
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_ready", in_ready0, 1);
        check("clr_valid", out_valid0, 0);
        check("clr_acc", acc0, 0);
        step();
        step();
        check("clr_acc_later", acc0, 0);
        send_block({4{8'd1}}, {4{8'd2}}, 1'b0);
        finish_block(20'd8, 1'b0, 16'd8, 1'b0, 0);

        // clr discards a held result.
        send_block({4{8'd255}}, {4{8'd255}}, 1'b0);
        wait_valid(cnt);
        check("hold_before_clr", out_valid0, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_hold_valid", out_valid0, 0);
        check("clr_hold_ovf16", ovf1, 0);
        check("clr_hold_ready", in_ready0, 1);

        // Randomized blocks against the reference model.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 4; i++) begin
                va[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                vb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            end
            model(va, vb, 20, m20, o20);
            model(va, vb, 16, m16, o16);
            send_block(va, vb, 1'($urandom_range(0, 1)));
            finish_block(20'(m20), o20, 16'(m16), o16, int'($urandom_range(0, 3)));
        end

        // LEN=1 instance: every pair is its own block.
        for (int k = 0; k < 6; k++) begin
            a2 = (k == 0) ? 8'd15 : 8'($urandom);
            b2 = (k == 0) ? 8'd15 : 8'($urandom);
            in_valid2 = 1'b1;
            check("len1_ready", in_ready2, 1);
            step();
            in_valid2 = 1'b0;
            check("len1_drain_ready", in_ready2, 0);
            cnt = 0;
            while (out_valid2 !== 1'b1 && cnt < 10) begin
                step();
                cnt++;
            end
            check("len1_latency", cnt, 2);
            check("len1_acc", acc2, 64'(a2) * 64'(b2));
            check("len1_ovf", ovf2, 0);
            out_ready2 = 1'b1;
            step();
            out_ready2 = 1'b0;
            check("len1_release", out_valid2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
